// File: rtl/led_seq_pkg.sv
// Shared types and constants for the status-LED blink sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_seq_pkg;

    // Prescaler counter width; wide enough for any practical board clock divider.
    localparam int PRESC_W = 32;

    // 100 ms tick at the 27 MHz board clock: 27_000_000 * 0.1 - 1.
    localparam int unsigned DEFAULT_TICK_DIV = 32'd2_699_999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } led_state_t;

endpackage

// File: rtl/led_blink_sequencer_arb.sv
// Round-robin pick of the first set request after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] idx;

    // Scan ptr+1, ptr+2, ... and keep the first requester found; ptr itself is checked last.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// Shares one active-low status LED among NUM_REQ requesters, playing N-blink bursts round-robin.
// Latency: request sampled in IDLE at cycle N; req_ready/grant_id/led update at N+1.
// Backpressure: req_valid is ignored while busy; requesters hold valid/count until req_ready.
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter int          CNT_W     = 4,
    parameter int unsigned TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int          GAP_TICKS = 5
) (
    input  logic                       sys_clk,
    input  logic                       sys_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*CNT_W-1:0]   req_count,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       led
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    led_state_t         state;
    led_state_t         state_nxt;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remaining_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               arb_any;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   sel_count;
    logic [NUM_REQ-1:0] grant_oh;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .any    (arb_any),
        .winner (win_idx)
    );

    assign tick     = (presc_cnt == PRESC_W'(TICK_DIV));
    assign grant_oh = NUM_REQ'(1) << win_idx;

    // Pull the winning requester's count field out of the flat count bus.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_count = req_count[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, step blink phases and the gap on each tick.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        gap_nxt       = gap_cnt;
        accept        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (arb_any) begin
                    accept        = 1'b1;
                    remaining_nxt = sel_count;
                    // A zero count is acknowledged and dropped without lighting the LED.
                    if (sel_count != '0) begin
                        state_nxt = S_ON;
                    end
                end
            end
            S_ON: begin
                if (tick) begin
                    state_nxt = S_OFF;
                end
            end
            S_OFF: begin
                if (tick) begin
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = S_GAP;
                        gap_nxt   = GAP_W'(GAP_TICKS);
                    end else begin
                        state_nxt = S_ON;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    gap_nxt = gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Prescaler: free-running tick source, restarted on acceptance so the first ON phase is a full period.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            presc_cnt <= '0;
        end else if (accept || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            gap_cnt   <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            grant_id  <= '0;
            req_ready <= '0;
            led       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            gap_cnt   <= gap_nxt;
            req_ready <= accept ? grant_oh : '0;
            if (accept) begin
                ptr      <= win_idx;
                grant_id <= win_idx;
            end
            led  <= (state_nxt != S_ON);
            busy <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with P=4, GAP_TICKS=2, NUM_REQ=4.
// Latency: expects req_ready one cycle after the IDLE sampling edge.
// Backpressure: requesters drop req_valid in the cycle req_ready is seen.
module tb_led_blink_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic [3:0]  req_valid;
    logic [15:0] req_count;
    logic [3:0]  req_ready;
    logic        busy;
    logic [1:0]  grant_id;
    logic        led;

    int n_cmp = 0;
    int n_bad = 0;

    led_blink_sequencer #(
        .NUM_REQ   (4),
        .CNT_W     (4),
        .TICK_DIV  (3),
        .GAP_TICKS (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .req_valid (req_valid),
        .req_count (req_count),
        .req_ready (req_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .led       (led)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one clock and settle just past the rising edge.
    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset;
        sys_reset = 1'b1;
        req_valid = '0;
        req_count = '0;
        step;
        step;
        sys_reset = 1'b0;
    endtask

    task automatic test_reset;
        sys_reset = 1'b1;
        req_valid = 4'b1111;
        req_count = 16'h3333;
        step;
        step;
        n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL reset_led: got %b want 1", led); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        req_valid = '0;
        req_count = '0;
        sys_reset = 1'b0;
    endtask

    task automatic test_single_burst;
        logic exp_led;
        apply_reset;
        req_count[3:0] = 4'd2;
        req_valid = 4'b0001;
        step;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL single_grant: got %0d want 0", grant_id); end
        req_valid = 4'b0000;
        for (int k = 0; k < 24; k++) begin
            exp_led = ((k / 4) % 2 == 1) || (k >= 16);
            n_cmp++; if (led !== exp_led) begin n_bad++; $display("FAIL single_led[%0d]: got %b want %b", k, led, exp_led); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy[%0d]: got %b want 1", k, busy); end
            if (k == 1) begin
                n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
            end
            step;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
        n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL single_led_end: got %b want 1", led); end
    endtask

    task automatic test_fairness;
        int         exp_id;
        logic [3:0] exp_oh;
        int         w;
        int         b;
        apply_reset;
        req_count = 16'h1010;
        req_valid = 4'b1010;
        step;
        for (int g = 0; g < 4; g++) begin
            exp_id = (g % 2 == 0) ? 1 : 3;
            exp_oh = 4'b0001 << exp_id;
            w = 0;
            while (req_ready === 4'b0000 && w < 40) begin
                step;
                w++;
            end
            n_cmp++; if (req_ready !== exp_oh) begin n_bad++; $display("FAIL fair_ready[%0d]: got %b want %b", g, req_ready, exp_oh); end
            n_cmp++; if (grant_id !== 2'(exp_id)) begin n_bad++; $display("FAIL fair_grant[%0d]: got %0d want %0d", g, grant_id, exp_id); end
            if (g > 0) begin
                n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL fair_idle_gap[%0d]: got %0d want 1", g, w); end
            end
            b = 0;
            while (busy === 1'b1 && b < 40) begin
                b++;
                step;
            end
            n_cmp++; if (b !== 16) begin n_bad++; $display("FAIL fair_busy_len[%0d]: got %0d want 16", g, b); end
        end
        req_valid = 4'b0000;
        step;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL fair_no_extra: got %b want 0000", req_ready); end
    endtask

    task automatic test_zero_count;
        apply_reset;
        req_count[11:8] = 4'd0;
        req_valid = 4'b0100;
        step;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL zero_ready: got %b want 0100", req_ready); end
        n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL zero_grant: got %0d want 2", grant_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
        n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL zero_led: got %b want 1", led); end
        req_valid = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            step;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL zero_ready_after[%0d]: got %b want 0000", k, req_ready); end
            n_cmp++; if (led !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_idle[%0d]: got led=%b busy=%b want led=1 busy=0", k, led, busy); end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic exp_led;
        apply_reset;
        req_count[3:0] = 4'd3;
        req_valid = 4'b0001;
        step;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_ready: got %b want 0001", req_ready); end
        for (int k = 0; k < 9; k++) step;
        n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL mid_second_on: got %b want 0", led); end
        sys_reset = 1'b1;
        step;
        n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL mid_reset_led: got %b want 1", led); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 0000", req_ready); end
        sys_reset = 1'b0;
        step;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_regrant: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        for (int k = 0; k < 32; k++) begin
            exp_led = ((k / 4) % 2 == 1) || (k >= 24);
            n_cmp++; if (led !== exp_led) begin n_bad++; $display("FAIL mid_replay_led[%0d]: got %b want %b", k, led, exp_led); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_replay_busy[%0d]: got %b want 1", k, busy); end
            step;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_replay_end: got %b want 0", busy); end
    endtask

    task automatic test_cancel;
        apply_reset;
        req_count = 16'h0021;
        req_valid = 4'b0001;
        step;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL cancel_first_ready: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        for (int k = 1; k < 28; k++) begin
            if (k == 3)  req_valid = 4'b0010;
            if (k == 10) req_valid = 4'b0000;
            step;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL cancel_ready[%0d]: got %b want 0000", k, req_ready); end
            if (k >= 16) begin
                n_cmp++; if (led !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL cancel_idle[%0d]: got led=%b busy=%b want led=1 busy=0", k, led, busy); end
            end
        end
    endtask

    initial begin
        sys_reset = 1'b1;
        req_valid = '0;
        req_count = '0;
        test_reset;
        test_single_burst;
        test_fairness;
        test_zero_count;
        test_reset_mid_burst;
        test_cancel;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
# led_blink_sequencer

Shares the board's single status LED between `NUM_REQ` requesters, each asking for a burst of N blinks. It arbitrates round-robin, plays the granted burst with fixed on/off periods from an internal prescaler, and inserts an inter-burst gap so consecutive bursts are distinguishable. It sits between the status sources (reset generator, error flags, UART activity, etc.) and the LED pin. It replaces any direct per-source blinker.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 4: width of each blink-count field.
- `TICK_DIV`, default 2_699_999: a tick fires every `TICK_DIV+1` clocks (100 ms at 27 MHz).
- `GAP_TICKS`, default 5: ticks of LED-off between bursts (≥1).

Ports:
- `sys_clk` in, 1: the single system clock.
- `sys_reset` in, 1: reset, synchronous, active-high.
- `req_valid` in, `NUM_REQ`: per-requester level request.
- `req_count` in, `NUM_REQ*CNT_W`: blink count. Requester i uses bits `[i*CNT_W +: CNT_W]`.
- `req_ready` out, `NUM_REQ`: one-cycle, one-hot acceptance pulse.
- `busy` out, 1: a burst or gap is in progress.
- `grant_id` out, `$clog2(NUM_REQ)`: index of the last accepted requester.
- `led` out, 1: LED drive, active low (0 = lit).

## Operation

- **Prescaler.** 32-bit counter counting 0..`TICK_DIV`. `tick` asserts for one cycle when the count equals `TICK_DIV`, then the count wraps to 0. The counter clears on acceptance, so phases are exact.
- **States:**
  - IDLE: led=1, busy=0.
  - ON: led=0.
  - OFF: led=1.
  - GAP: led=1.
- **IDLE.**
  - If any `req_valid` is set, pick the first set bit searching `ptr+1, ptr+2, …` modulo `NUM_REQ`.
  - Latch that requester's count into `remaining`, set `ptr` and `grant_id` to the winner, and pulse `req_ready[winner]` in the next cycle.
  - If the latched count is non-zero, go to ON. If it is 0, stay in IDLE: the request is acknowledged and dropped.
- **ON.** On `tick`, go to OFF.
- **OFF.** On `tick`, decrement `remaining`. If the new value is 0, go to GAP with the gap counter set to `GAP_TICKS`; otherwise go to ON.
- **GAP.** Decrement the gap counter on each `tick`. When it reaches 0, go to IDLE.
- `busy` = state is not IDLE.
- **Requester contract.**
  - Hold `req_valid` and `req_count` stable until `req_ready`.
  - Dropping `req_valid` before it is sampled in IDLE cancels the request with no pulse.
  - `req_valid` is ignored while busy.
  - After `req_ready`, a requester that keeps `req_valid` high is treated as a new request.
- **Round-robin fairness.** `ptr` resets to `NUM_REQ-1`, so requester 0 has first priority after reset. With all requesters valid, grants rotate 0, 1, …, `NUM_REQ-1`.
- **Arithmetic.** `remaining` is `CNT_W` wide with no wrap (a 0 count never enters ON). The maximum burst is `2^CNT_W-1` blinks.
- **Reset.**
  - Values: state=IDLE, led=1, busy=0, req_ready=0, grant_id=0, ptr=`NUM_REQ-1`, prescaler=0.
  - Mid-burst reset aborts the burst immediately. The aborted requester is not re-acknowledged and must re-request.

## Timing

- **Grant latency.**
  - Cycle N: IDLE samples `req_valid`.
  - Cycle N+1: `req_ready` pulses, `grant_id` updates, and led=0 if count>0.
- **Burst duration.** Let P = `TICK_DIV+1`. For count C>0, led is low for P cycles, then high for P cycles, repeated C times, then high for `GAP_TICKS*P` cycles.
  - `busy` is high for exactly `(2C+GAP_TICKS)*P` cycles, starting at N+1.
- **Back-to-back.** The earliest next acceptance samples in the first IDLE cycle after GAP; the next LED-low follows one cycle later.
- **Zero count.** `req_ready` pulses at N+1 and `busy` stays 0. The next arbitration can sample at N+1, but the same requester is not re-chosen while others are valid.
- **Registered outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `led_seq_pkg`:
  - State encoding IDLE/ON/OFF/GAP.
  - Prescaler width constant (32).
  - Default `TICK_DIV` for the 27 MHz board clock.
- Sub-module `rr_arbiter`, combinational: takes `req`, `ptr`, and `NUM_REQ`, and returns `any` plus the winner index. It is reusable for other shared board resources.
- Prescaler and FSM live in `led_blink_sequencer`.

## Test plan

All scenarios use `TICK_DIV=3` (P=4), `GAP_TICKS=2`, `NUM_REQ=4`.

- **Reset values:** hold `sys_reset` for 2 cycles -> led=1, busy=0, req_ready=0000, grant_id=0.
- **Single burst:** req0 valid with count=2 at cycle N -> `req_ready`=0001 at N+1; led pattern low 4 / high 4 / low 4 / high 4, then high 8; busy high for 24 cycles.
- **Fairness:** req1 and req3 held valid with count=1 -> grant order 1, 3, 1, 3; each busy period is 16 cycles; `grant_id` tracks each grant.
- **Zero count:** req2 count=0 -> `req_ready`=0100 for one cycle, led stays 1, busy stays 0.
- **Reset mid-burst:** assert `sys_reset` during the second ON phase -> the next cycle shows led=1 and busy=0. After release, the still-valid requester is re-granted and its full count replays.
- **Cancel:** deassert `req_valid` before IDLE samples it -> no `req_ready`, no LED activity.
